db_arbiter: RTL and testbench
=============================

# db_arbiter

Two-master arbiter for the single `db_*` memory/IO bus. It lets the MipsCPU (master 0) and a second requester such as a loader or DMA engine (master 1) share one memory/IO slave. It sits between the masters and the slave, grants the bus one transaction at a time with round-robin fairness, routes read data back to the owner, and aborts transactions the slave never acknowledges.

## Interface
- `TIMEOUT`, 1024: cycles a granted transaction may wait for `db_ready` before it is aborted. Must be ≥1.
- `CNT_W`, 11: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT.
- `clk` in 1: clock. All logic is on the rising edge.
- `res` in 1: reset, synchronous, active-high.
- `mN_re`, `mN_we`, `mN_io` in 1 each (N=0,1): master N request strobes and IO-space select.
- `mN_addr`, `mN_dataOut` in 32 each: master N address and write data.
- `mN_ready` out 1: master N transaction accepted this cycle.
- `mN_rvalid` out 1: master N read data valid on `mN_dataIn`.
- `mN_err` out 1: one-cycle pulse when master N's transaction timed out.
- `mN_dataIn` out 32: read data to master N.
- `db_re`, `db_we`, `db_io` out 1 each: slave strobes.
- `db_addr`, `db_dataOut` out 32 each: slave address and write data.
- `db_dataIn` in 32: slave read data. Valid the cycle after a read is accepted.
- `db_ready` in 1: slave accepts the presented transaction at this edge.

## Operation
- A request from master N is `mN_re | mN_we`. If both strobes are high, it is treated as a write.
- A master holds its strobes, addr, io and dataOut stable until it sees `mN_ready` or `mN_err`.
- FSM states: IDLE, GNT0, GNT1, RDATA.
- IDLE:
  - Slave strobes are 0.
  - If only one master requests, go to that master's GNTx.
  - If both request, grant the master that is not `last`. `last` is a 1-bit register, reset to 1, so master 0 wins the first tie.
  - If neither requests, stay in IDLE.
- GNTx:
  - `db_re/we/io/addr/dataOut` mirror master x combinationally. `mx_ready = db_ready`.
  - The other master's ready, rvalid and err are 0.
  - Timeout counter clears on entry and increments each cycle `db_ready` is 0.
  - At the edge with `db_ready=1`:
    - Set `last <= x`.
    - A write goes to IDLE.
    - A read goes to RDATA with the owner register = x.
  - If the counter reaches `TIMEOUT-1` with `db_ready=0`:
    - Pulse `mx_err` for one cycle (registered, asserted in the next state).
    - Set `last <= x` and go to IDLE.
    - Slave strobes drop in that next cycle.
- RDATA:
  - `m<owner>_rvalid=1`.
  - Slave strobes are 0.
  - Always returns to IDLE.
- `db_dataIn` is wired to both `m0_dataIn` and `m1_dataIn`. Only `rvalid` qualifies it.
- A master that drops its request while in GNTx is a protocol violation. The arbiter stays in GNTx until `db_ready` or timeout; the bench must not do this.

## Timing
- Reset values:
  - State IDLE, `last`=1, counter 0.
  - All `mN_ready/rvalid/err`=0.
  - `db_re/we/io`=0, `db_addr/db_dataOut`=0.
- Reset is sampled only at `clk`. Asserting `res` mid-transaction forces IDLE at the next edge, and slave strobes are 0 from that cycle on. An in-flight read never produces `rvalid`.
- Latency with an always-ready slave:
  - Request seen in IDLE at cycle 0.
  - GNT and accept (`mN_ready`=1) at cycle 1.
  - Read data and `rvalid` at cycle 2.
  - Back in IDLE at cycle 3. A write is back in IDLE at cycle 2.
- Throughput: a write takes 2 cycles and a read takes 3, because every transaction passes through IDLE.
- Arbitration fairness: with both masters continuously requesting, grants strictly alternate.
- Timeout: the abort edge is the `TIMEOUT`th cycle in GNTx without `db_ready`. `mx_err` is high in the following cycle.
- A `db_ready` that arrives on the same edge as the timeout wins: the transaction completes and no err is raised.

## Test plan
- Single read: m0 reads addr 0x100 from a slave with `db_ready`=1 holding 0xDEADBEEF. Required: `db_re`=1 in cycle 1 only; `m0_ready` in cycle 1; `m0_rvalid` with data 0xDEADBEEF in cycle 2; m1 outputs all 0.
- Contention: m0 and m1 both write continuously from reset, m0 to 0x0 and m1 to 0x4. Required: the slave sees m0, m1, m0, m1… with one grant every 2 cycles. `db_addr` alternates 0x0 and 0x4.
- Wait states: the slave holds `db_ready`=0 for 5 cycles during an m1 read. Required: `db_re` and `db_addr` are stable for 6 cycles; `m1_ready` is high only in the 6th; `m1_rvalid` is high the next cycle; m0 is stalled throughout.
- Timeout: `TIMEOUT`=8, slave never ready, m0 writes. Required: `m0_err` pulses 1 cycle after the 8th GNT0 cycle; `db_we`=0 afterwards; then m1's pending request is granted.
- Timeout tie: `db_ready` rises exactly on the 8th GNT cycle. Required: `m0_ready`=1 and no `m0_err`.
- Reset mid-read: assert `res` for 1 cycle while in GNT0 (slave stalled). Required: IDLE next cycle, all outputs at reset values, no `rvalid`; the next tie goes to m0.

Source files
------------

// File: rtl/db_arbiter.sv
// Round-robin arbiter sharing the single db_* slave between two masters,
// routing read data to the owner and aborting unacknowledged transactions.
module db_arbiter #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 11
) (
    input  logic        clk,
    input  logic        res,
    input  logic        m0_re,
    input  logic        m0_we,
    input  logic        m0_io,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_dataOut,
    output logic        m0_ready,
    output logic        m0_rvalid,
    output logic        m0_err,
    output logic [31:0] m0_dataIn,
    input  logic        m1_re,
    input  logic        m1_we,
    input  logic        m1_io,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_dataOut,
    output logic        m1_ready,
    output logic        m1_rvalid,
    output logic        m1_err,
    output logic [31:0] m1_dataIn,
    output logic        db_re,
    output logic        db_we,
    output logic        db_io,
    output logic [31:0] db_addr,
    output logic [31:0] db_dataOut,
    input  logic [31:0] db_dataIn,
    input  logic        db_ready
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT0  = 2'd1;
    localparam logic [1:0] GNT1  = 2'd2;
    localparam logic [1:0] RDATA = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic             last;
    logic             owner;
    logic [CNT_W-1:0] cnt;
    logic             err0_q;
    logic             err1_q;

    logic req0;
    logic req1;
    logic gnt_sel;
    logic sel_we;

    assign req0    = m0_re | m0_we;
    assign req1    = m1_re | m1_we;
    assign gnt_sel = (state == GNT1);
    assign sel_we  = gnt_sel ? m1_we : m0_we;

    // On a tie the master that did not finish last wins; db_ready beats the timeout.
    always_ff @(posedge clk) begin
        if (res) begin
            state  <= IDLE;
            last   <= 1'b1;
            owner  <= 1'b0;
            cnt    <= '0;
            err0_q <= 1'b0;
            err1_q <= 1'b0;
        end else begin
            err0_q <= 1'b0;
            err1_q <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req0 && (!req1 || last)) begin
                        state <= GNT0;
                    end else if (req1) begin
                        state <= GNT1;
                    end
                end
                GNT0, GNT1: begin
                    if (db_ready) begin
                        last  <= gnt_sel;
                        owner <= gnt_sel;
                        state <= sel_we ? IDLE : RDATA;
                    end else if (cnt == CNT_LAST) begin
                        last   <= gnt_sel;
                        err0_q <= !gnt_sel;
                        err1_q <= gnt_sel;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        db_re      = 1'b0;
        db_we      = 1'b0;
        db_io      = 1'b0;
        db_addr    = '0;
        db_dataOut = '0;
        if (state == GNT0) begin
            db_re      = m0_re;
            db_we      = m0_we;
            db_io      = m0_io;
            db_addr    = m0_addr;
            db_dataOut = m0_dataOut;
        end else if (state == GNT1) begin
            db_re      = m1_re;
            db_we      = m1_we;
            db_io      = m1_io;
            db_addr    = m1_addr;
            db_dataOut = m1_dataOut;
        end
    end

    assign m0_ready  = (state == GNT0) && db_ready;
    assign m1_ready  = (state == GNT1) && db_ready;
    assign m0_rvalid = (state == RDATA) && !owner;
    assign m1_rvalid = (state == RDATA) && owner;
    assign m0_err    = err0_q;
    assign m1_err    = err1_q;
    assign m0_dataIn = db_dataIn;
    assign m1_dataIn = db_dataIn;

endmodule

// File: tb/tb_db_arbiter.sv
// Testbench for db_arbiter: directed timing scenarios plus a randomized run
// against a transaction-level model of the arbitration rules.
module tb_db_arbiter;

    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 4;

    logic        clk = 1'b0;
    logic        res;
    logic        m0_re, m0_we, m0_io;
    logic [31:0] m0_addr, m0_dataOut, m0_dataIn;
    logic        m0_ready, m0_rvalid, m0_err;
    logic        m1_re, m1_we, m1_io;
    logic [31:0] m1_addr, m1_dataOut, m1_dataIn;
    logic        m1_ready, m1_rvalid, m1_err;
    logic        db_re, db_we, db_io, db_ready;
    logic [31:0] db_addr, db_dataOut, db_dataIn;
    logic [8:0]  ctl;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign ctl = {db_re, db_we, db_io, m0_ready, m0_rvalid, m0_err, m1_ready, m1_rvalid, m1_err};

    db_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .res(res),
        .m0_re(m0_re), .m0_we(m0_we), .m0_io(m0_io), .m0_addr(m0_addr), .m0_dataOut(m0_dataOut),
        .m0_ready(m0_ready), .m0_rvalid(m0_rvalid), .m0_err(m0_err), .m0_dataIn(m0_dataIn),
        .m1_re(m1_re), .m1_we(m1_we), .m1_io(m1_io), .m1_addr(m1_addr), .m1_dataOut(m1_dataOut),
        .m1_ready(m1_ready), .m1_rvalid(m1_rvalid), .m1_err(m1_err), .m1_dataIn(m1_dataIn),
        .db_re(db_re), .db_we(db_we), .db_io(db_io), .db_addr(db_addr), .db_dataOut(db_dataOut),
        .db_dataIn(db_dataIn), .db_ready(db_ready)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    // Slave read port: data appears the cycle after a read is accepted, garbage otherwise.
    task automatic cyc();
        logic        acc;
        logic [31:0] a;
        acc = db_re && !db_we && db_ready;
        a   = db_addr;
        @(posedge clk);
        #1;
        db_dataIn = (acc === 1'b1) ? mem_word(a) : $urandom;
    endtask

    task automatic set_m0(input logic re, input logic we, input logic io,
                          input logic [31:0] addr, input logic [31:0] data);
        m0_re = re; m0_we = we; m0_io = io; m0_addr = addr; m0_dataOut = data;
    endtask

    task automatic set_m1(input logic re, input logic we, input logic io,
                          input logic [31:0] addr, input logic [31:0] data);
        m1_re = re; m1_we = we; m1_io = io; m1_addr = addr; m1_dataOut = data;
    endtask

    task automatic clear_masters();
        set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        set_m0(1'b1, 1'b0, 1'b1, 32'h55, 32'h66);
        set_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        db_ready = 1'b1;
        res = 1'b1;
        cyc();
        cyc();
        @(negedge clk);
        checks++;
        if (ctl !== 9'b0) begin
            errors++; $display("[TB] FAIL reset_ctl: got %b required %b", ctl, 9'b0);
        end
        checks++;
        if ({db_addr, db_dataOut} !== 64'd0) begin
            errors++; $display("[TB] FAIL reset_bus: got %h required %h", {db_addr, db_dataOut}, 64'd0);
        end
        clear_masters();
        res = 1'b0;
        cyc();
    endtask

    task automatic test_single_read();
        set_m0(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
        db_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== 9'b000_000_000) begin
            errors++; $display("[TB] FAIL read_c0_ctl: got %b required %b", ctl, 9'b000_000_000);
        end
        cyc();
        @(negedge clk);
        checks++;
        if (ctl !== 9'b100_100_000) begin
            errors++; $display("[TB] FAIL read_c1_ctl: got %b required %b", ctl, 9'b100_100_000);
        end
        checks++;
        if (db_addr !== 32'h100) begin
            errors++; $display("[TB] FAIL read_c1_addr: got %h required %h", db_addr, 32'h100);
        end
        cyc();
        clear_masters();
        @(negedge clk);
        checks++;
        if (ctl !== 9'b000_010_000) begin
            errors++; $display("[TB] FAIL read_c2_ctl: got %b required %b", ctl, 9'b000_010_000);
        end
        checks++;
        if (m0_dataIn !== 32'hDEADBEEF) begin
            errors++; $display("[TB] FAIL read_c2_data: got %h required %h", m0_dataIn, 32'hDEADBEEF);
        end
        cyc();
        @(negedge clk);
        checks++;
        if (ctl !== 9'b000_000_000) begin
            errors++; $display("[TB] FAIL read_c3_ctl: got %b required %b", ctl, 9'b000_000_000);
        end
        cyc();
    endtask

    task automatic test_contention();
        int          exp_m;
        logic [8:0]  exp_ctl;
        logic [63:0] exp_bus;
        set_m0(1'b0, 1'b1, 1'b0, 32'h0, 32'hA0);
        set_m1(1'b0, 1'b1, 1'b0, 32'h4, 32'hB1);
        db_ready = 1'b1;
        res = 1'b1;
        cyc();
        res = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c % 2 == 1) begin
                exp_m   = ((c - 1) / 2) % 2;
                exp_ctl = (exp_m == 0) ? 9'b010_100_000 : 9'b010_000_100;
                exp_bus = (exp_m == 0) ? {32'h0, 32'hA0} : {32'h4, 32'hB1};
                checks++;
                if ({db_addr, db_dataOut} !== exp_bus) begin
                    errors++; $display("[TB] FAIL contention_bus c%0d: got %h required %h", c, {db_addr, db_dataOut}, exp_bus);
                end
            end else begin
                exp_ctl = 9'b0;
            end
            checks++;
            if (ctl !== exp_ctl) begin
                errors++; $display("[TB] FAIL contention_ctl c%0d: got %b required %b", c, ctl, exp_ctl);
            end
            cyc();
        end
        clear_masters();
        cyc();
    endtask

    task automatic test_wait_states();
        logic [8:0] exp_ctl;
        set_m1(1'b1, 1'b0, 1'b1, 32'h200, 32'h0);
        db_ready = 1'b0;
        @(negedge clk);
        for (int i = 1; i <= 6; i++) begin
            cyc();
            if (i == 1) set_m0(1'b0, 1'b1, 1'b0, 32'h300, 32'h1234);
            db_ready = (i == 6);
            @(negedge clk);
            exp_ctl = {3'b101, 3'b000, (i == 6), 2'b00};
            checks++;
            if (ctl !== exp_ctl) begin
                errors++; $display("[TB] FAIL wait_ctl c%0d: got %b required %b", i, ctl, exp_ctl);
            end
            checks++;
            if (db_addr !== 32'h200) begin
                errors++; $display("[TB] FAIL wait_addr c%0d: got %h required %h", i, db_addr, 32'h200);
            end
        end
        cyc();
        set_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        db_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== 9'b000_000_010) begin
            errors++; $display("[TB] FAIL wait_rvalid_ctl: got %b required %b", ctl, 9'b000_000_010);
        end
        checks++;
        if (m1_dataIn !== mem_word(32'h200)) begin
            errors++; $display("[TB] FAIL wait_rdata: got %h required %h", m1_dataIn, mem_word(32'h200));
        end
        cyc();
        @(negedge clk);
        checks++;
        if (ctl !== 9'b000_000_000) begin
            errors++; $display("[TB] FAIL wait_idle_ctl: got %b required %b", ctl, 9'b000_000_000);
        end
        cyc();
        @(negedge clk);
        checks++;
        if ({ctl, db_addr} !== {9'b010_100_000, 32'h300}) begin
            errors++; $display("[TB] FAIL wait_m0_grant: got %b/%h required %b/%h", ctl, db_addr, 9'b010_100_000, 32'h300);
        end
        cyc();
        clear_masters();
        cyc();
    endtask

    task automatic test_timeout();
        set_m0(1'b0, 1'b1, 1'b0, 32'h400, 32'hCAFE);
        db_ready = 1'b0;
        @(negedge clk);
        for (int i = 1; i <= TIMEOUT; i++) begin
            cyc();
            if (i == 1) set_m1(1'b1, 1'b0, 1'b0, 32'h500, 32'h0);
            @(negedge clk);
            checks++;
            if (ctl !== 9'b010_000_000) begin
                errors++; $display("[TB] FAIL timeout_wait_ctl c%0d: got %b required %b", i, ctl, 9'b010_000_000);
            end
        end
        cyc();
        @(negedge clk);
        checks++;
        if (ctl !== 9'b000_001_000) begin
            errors++; $display("[TB] FAIL timeout_err_ctl: got %b required %b", ctl, 9'b000_001_000);
        end
        cyc();
        set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        db_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({ctl, db_addr} !== {9'b100_000_100, 32'h500}) begin
            errors++; $display("[TB] FAIL timeout_m1_grant: got %b/%h required %b/%h", ctl, db_addr, 9'b100_000_100, 32'h500);
        end
        cyc();
        clear_masters();
        @(negedge clk);
        checks++;
        if (ctl !== 9'b000_000_010) begin
            errors++; $display("[TB] FAIL timeout_m1_rvalid: got %b required %b", ctl, 9'b000_000_010);
        end
        cyc();
        cyc();
    endtask

    task automatic test_timeout_tie();
        logic [8:0] exp_ctl;
        set_m0(1'b0, 1'b1, 1'b0, 32'h600, 32'h77);
        db_ready = 1'b0;
        @(negedge clk);
        for (int i = 1; i <= TIMEOUT; i++) begin
            cyc();
            db_ready = (i == TIMEOUT);
            @(negedge clk);
            exp_ctl = {3'b010, (i == TIMEOUT), 5'b00000};
            checks++;
            if (ctl !== exp_ctl) begin
                errors++; $display("[TB] FAIL tie_ctl c%0d: got %b required %b", i, ctl, exp_ctl);
            end
        end
        cyc();
        clear_masters();
        @(negedge clk);
        checks++;
        if (ctl !== 9'b000_000_000) begin
            errors++; $display("[TB] FAIL tie_no_err: got %b required %b", ctl, 9'b000_000_000);
        end
        cyc();
    endtask

    task automatic test_reset_mid_read();
        set_m0(1'b1, 1'b0, 1'b0, 32'h700, 32'h0);
        db_ready = 1'b0;
        @(negedge clk);
        cyc();
        @(negedge clk);
        checks++;
        if (ctl !== 9'b100_000_000) begin
            errors++; $display("[TB] FAIL rst_mid_gnt: got %b required %b", ctl, 9'b100_000_000);
        end
        cyc();
        res = 1'b1;
        @(negedge clk);
        cyc();
        res = 1'b0;
        set_m1(1'b1, 1'b0, 1'b0, 32'h704, 32'h0);
        db_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({ctl, db_addr, db_dataOut} !== {9'b0, 64'd0}) begin
            errors++; $display("[TB] FAIL rst_mid_idle: got %b/%h/%h required all zero", ctl, db_addr, db_dataOut);
        end
        cyc();
        @(negedge clk);
        checks++;
        if ({ctl, db_addr} !== {9'b100_100_000, 32'h700}) begin
            errors++; $display("[TB] FAIL rst_mid_tie: got %b/%h required %b/%h", ctl, db_addr, 9'b100_100_000, 32'h700);
        end
        cyc();
        set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checks++;
        if (ctl !== 9'b000_010_000) begin
            errors++; $display("[TB] FAIL rst_mid_rvalid: got %b required %b", ctl, 9'b000_010_000);
        end
        cyc();
        cyc();
        @(negedge clk);
        checks++;
        if ({ctl, db_addr} !== {9'b100_000_100, 32'h704}) begin
            errors++; $display("[TB] FAIL rst_mid_m1: got %b/%h required %b/%h", ctl, db_addr, 9'b100_000_100, 32'h704);
        end
        cyc();
        clear_masters();
        cyc();
        cyc();
    endtask

    // Model: owner of the bus (-1 none), cycles it has held it, pending read
    // data (-1 none), and which master is preferred on the next tie.
    task automatic test_random();
        logic        a_re[2], a_we[2], a_io[2], active[2], done[2], err_q[2], new_err[2];
        logic [31:0] a_addr[2], a_data[2];
        logic [31:0] due_addr, exp_addr, exp_dout, got_data;
        logic [8:0]  exp_ctl;
        int          owner, held, due, pref, new_due, ready_pct, kind;
        clear_masters();
        db_ready = 1'b0;
        res = 1'b1;
        cyc();
        res = 1'b0;
        owner = -1; held = 0; due = -1; pref = 0; due_addr = '0;
        for (int m = 0; m < 2; m++) begin
            active[m] = 1'b0; done[m] = 1'b0; err_q[m] = 1'b0;
            a_re[m] = 1'b0; a_we[m] = 1'b0; a_io[m] = 1'b0; a_addr[m] = '0; a_data[m] = '0;
        end
        for (int c = 0; c < 400; c++) begin
            ready_pct = (c < 200) ? 70 : 15;
            for (int m = 0; m < 2; m++) begin
                if (done[m]) active[m] = 1'b0;
                if (!active[m] && $urandom_range(0, 99) < 45) begin
                    active[m] = 1'b1;
                    kind      = $urandom_range(0, 2);
                    a_re[m]   = (kind != 1);
                    a_we[m]   = (kind != 0);
                    a_io[m]   = 1'($urandom_range(0, 1));
                    a_addr[m] = $urandom & 32'h0000_FFFC;
                    a_data[m] = $urandom;
                end
                if (!active[m]) begin
                    a_re[m] = 1'b0;
                    a_we[m] = 1'b0;
                end
            end
            set_m0(a_re[0], a_we[0], a_io[0], a_addr[0], a_data[0]);
            set_m1(a_re[1], a_we[1], a_io[1], a_addr[1], a_data[1]);
            db_ready = ($urandom_range(0, 99) < ready_pct);
            @(negedge clk);
            exp_ctl = '0; exp_addr = '0; exp_dout = '0;
            if (owner >= 0) begin
                exp_ctl[8] = a_re[owner];
                exp_ctl[7] = a_we[owner];
                exp_ctl[6] = a_io[owner];
                exp_addr   = a_addr[owner];
                exp_dout   = a_data[owner];
            end
            if (owner == 0) exp_ctl[5] = db_ready;
            if (owner == 1) exp_ctl[2] = db_ready;
            exp_ctl[4] = (due == 0);
            exp_ctl[1] = (due == 1);
            exp_ctl[3] = err_q[0];
            exp_ctl[0] = err_q[1];
            checks++;
            if (ctl !== exp_ctl) begin
                errors++; $display("[TB] FAIL rand_ctl c%0d: got %b required %b", c, ctl, exp_ctl);
            end
            if (owner >= 0) begin
                checks++;
                if ({db_addr, db_dataOut} !== {exp_addr, exp_dout}) begin
                    errors++; $display("[TB] FAIL rand_bus c%0d: got %h required %h", c, {db_addr, db_dataOut}, {exp_addr, exp_dout});
                end
            end
            if (due >= 0) begin
                got_data = (due == 0) ? m0_dataIn : m1_dataIn;
                checks++;
                if (got_data !== mem_word(due_addr)) begin
                    errors++; $display("[TB] FAIL rand_rdata c%0d: got %h required %h", c, got_data, mem_word(due_addr));
                end
            end
            done[0] = exp_ctl[5] | exp_ctl[3];
            done[1] = exp_ctl[2] | exp_ctl[0];
            new_err[0] = 1'b0;
            new_err[1] = 1'b0;
            new_due    = -1;
            if (owner >= 0) begin
                held++;
                if (db_ready) begin
                    pref = 1 - owner;
                    if (!a_we[owner]) begin
                        new_due  = owner;
                        due_addr = a_addr[owner];
                    end
                    owner = -1;
                end else if (held == TIMEOUT) begin
                    new_err[owner] = 1'b1;
                    pref  = 1 - owner;
                    owner = -1;
                end
            end else if (due < 0) begin
                held = 0;
                if (active[0] && active[1]) owner = pref;
                else if (active[0]) owner = 0;
                else if (active[1]) owner = 1;
            end
            due      = new_due;
            err_q[0] = new_err[0];
            err_q[1] = new_err[1];
            cyc();
        end
        clear_masters();
        cyc();
    endtask

    initial begin
        res = 1'b1;
        db_ready = 1'b0;
        db_dataIn = '0;
        clear_masters();
        test_reset();
        test_single_read();
        test_contention();
        test_wait_states();
        test_timeout();
        test_timeout_tie();
        test_reset_mid_read();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish required finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
